// File: rtl/pixel_in_fifo.sv
// Synchronous input pixel FIFO feeding the detection core, with almost_full back-pressure.
// Optional frame tagging of the last pixel per frame is enabled by PIXEL_FIFO_FRAME_CNT_EN.
module pixel_in_fifo #(
  parameter int DATA_WIDTH   = 24,
  parameter int DEPTH        = 512,
  parameter int AF_MARGIN    = 8,
  parameter int FRAME_PIXELS = 65536
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf,
  output logic                         udf,
  output logic                         o_last
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pixel_in_fifo: DEPTH must be a power of two >= 4");
  end
  if (FRAME_PIXELS < 2) begin : g_bad_frame
    $error("pixel_in_fifo: FRAME_PIXELS must be >= 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_push;
  logic                  w_pop;
  logic [CW:0]           w_free;

  assign full        = (r_count == CW'(DEPTH));
  assign empty       = (r_count == {CW{1'b0}});
  assign w_free      = (CW+1)'(DEPTH) - {1'b0, r_count};
  assign almost_full = (w_free <= (CW+1)'(AF_MARGIN));
  assign count       = r_count;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign ovf         = r_ovf;
  assign udf         = r_udf;

  // A pop frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign w_pop  = rd_en && !empty;
  assign w_push = wr_en && (!full || w_pop);

  // Storage array is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_data   <= {DATA_WIDTH{1'b0}};
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        r_udf <= 1'b1;
      end
    end
  end

`ifdef PIXEL_FIFO_FRAME_CNT_EN
  localparam int FW = $clog2(FRAME_PIXELS);

  logic [FW-1:0] r_pix_cnt;
  logic          r_last;

  assign o_last = r_last;

  // Tag lines up with o_valid because both register off the same pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt <= {FW{1'b0}};
      r_last    <= 1'b0;
    end else begin
      r_last <= w_pop && (r_pix_cnt == FW'(FRAME_PIXELS - 1));
      if (w_pop) begin
        if (r_pix_cnt == FW'(FRAME_PIXELS - 1)) begin
          r_pix_cnt <= {FW{1'b0}};
        end else begin
          r_pix_cnt <= r_pix_cnt + FW'(1);
        end
      end
    end
  end
`else
  assign o_last = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_in_fifo.sv
// Directed bench for pixel_in_fifo: vector table for basic flow, loops for fill/full/frame cases.
module tb_pixel_in_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 512;
  localparam int AFM   = 8;
  localparam int FP    = 16;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef PIXEL_FIFO_FRAME_CNT_EN
  localparam logic FRAME_EN = 1'b1;
`else
  localparam logic FRAME_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf;
  logic          udf;
  logic          o_last;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          ee;
    logic          eu;
  } vec_t;

  vec_t vt[15];

  always #5 clk = ~clk;

  pixel_in_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AF_MARGIN   (AFM),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .almost_full(almost_full),
    .rd_en      (rd_en),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .empty      (empty),
    .count      (count),
    .ovf        (ovf),
    .udf        (udf),
    .o_last     (o_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_data"},  32'(o_data), 32'h0);
    chk({tag, "_valid"}, 32'(o_valid), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_full"},  32'(full), 32'h0);
    chk({tag, "_af"},    32'(almost_full), 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_ovf"},   32'(ovf), 32'h0);
    chk({tag, "_udf"},   32'(udf), 32'h0);
    chk({tag, "_last"},  32'(o_last), 32'h0);
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    logic [DW-1:0] d;
    logic          exp_last;

    //            w     r     d           ev    ed          ec      ee    eu
    vt[0]  = '{1'b1, 1'b0, 24'h000001, 1'b0, 24'h000000, 10'd1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 24'h000002, 1'b0, 24'h000000, 10'd2, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 24'h000003, 1'b0, 24'h000000, 10'd3, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 24'h000004, 1'b0, 24'h000000, 10'd4, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'h000001, 10'd3, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'h000002, 10'd2, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'h000003, 10'd1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'h000004, 10'd0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 24'h000000, 1'b0, 24'h000004, 10'd0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 24'h555555, 1'b0, 24'h000004, 10'd1, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'h555555, 10'd0, 1'b1, 1'b1};
    vt[11] = '{1'b1, 1'b0, 24'hAAAAAA, 1'b0, 24'h555555, 10'd1, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b1, 24'hBBBBBB, 1'b1, 24'hAAAAAA, 10'd1, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b1, 24'h000000, 1'b1, 24'hBBBBBB, 10'd0, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 24'h000000, 1'b0, 24'hBBBBBB, 10'd0, 1'b1, 1'b1};

    step(1'b0, 1'b0, 24'h0, 1'b1);
    check_reset_state("rst0");

    for (int i = 0; i < 15; i++) begin
      step(vt[i].w, vt[i].r, vt[i].d, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_data", i),  32'(o_data),  32'(vt[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(count),   32'(vt[i].ec));
      chk($sformatf("vec%0d_empty", i), 32'(empty),   32'(vt[i].ee));
      chk($sformatf("vec%0d_udf", i),   32'(udf),     32'(vt[i].eu));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),     32'h0);
    end

    // Fill to full, watching almost_full and full thresholds.
    step(1'b0, 1'b0, 24'h0, 1'b1);
    check_reset_state("rst1");
    q.delete();
    for (int i = 1; i <= DEPTH; i++) begin
      d = 24'(i);
      step(1'b1, 1'b0, d, 1'b0);
      q.push_back(d);
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      chk($sformatf("fill%0d_af", i),    32'(almost_full), (i >= DEPTH - AFM) ? 32'h1 : 32'h0);
      chk($sformatf("fill%0d_full", i),  32'(full), (i == DEPTH) ? 32'h1 : 32'h0);
    end

    // Sustained push+pop at full.
    for (int k = 0; k < 100; k++) begin
      d = 24'h100000 + 24'(k);
      step(1'b1, 1'b1, d, 1'b0);
      exp_d = q.pop_front();
      q.push_back(d);
      chk($sformatf("pp%0d_valid", k), 32'(o_valid), 32'h1);
      chk($sformatf("pp%0d_data", k),  32'(o_data), 32'(exp_d));
      chk($sformatf("pp%0d_count", k), 32'(count), 32'(DEPTH));
      chk($sformatf("pp%0d_ovf", k),   32'(ovf), 32'h0);
    end

    // Overflow write is dropped.
    step(1'b1, 1'b0, 24'hABCDEF, 1'b0);
    chk("ovf_set",   32'(ovf), 32'h1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_full",  32'(full), 32'h1);
    chk("ovf_valid", 32'(o_valid), 32'h0);

    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b1, 24'h0, 1'b0);
      exp_d = q.pop_front();
      chk($sformatf("drain%0d_valid", k), 32'(o_valid), 32'h1);
      chk($sformatf("drain%0d_data", k),  32'(o_data), 32'(exp_d));
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_full",  32'(full), 32'h0);
    chk("drain_af",    32'(almost_full), 32'h0);
    step(1'b0, 1'b1, 24'h0, 1'b0);
    chk("drain_extra_valid", 32'(o_valid), 32'h0);
    chk("drain_extra_udf",   32'(udf), 32'h1);

    // Frame tagging over 40 pops.
    step(1'b0, 1'b0, 24'h0, 1'b1);
    check_reset_state("rst2");
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b0, 24'(k), 1'b0);
    end
    chk("frame_count", 32'(count), 32'd40);
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, 24'h0, 1'b0);
      exp_last = FRAME_EN && ((k == FP) || (k == 2 * FP));
      chk($sformatf("frame%0d_valid", k), 32'(o_valid), 32'h1);
      chk($sformatf("frame%0d_data", k),  32'(o_data), 32'(k));
      chk($sformatf("frame%0d_last", k),  32'(o_last), 32'(exp_last));
    end
    step(1'b0, 1'b0, 24'h0, 1'b0);
    chk("frame_idle_last", 32'(o_last), 32'h0);

    // Reset mid-stream with active inputs.
    step(1'b0, 1'b1, 24'h0, 1'b0);
    chk("mid_udf_pre", 32'(udf), 32'h1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 24'h200000 + 24'(k), 1'b0);
    end
    chk("mid_count_pre", 32'(count), 32'd10);
    step(1'b1, 1'b1, 24'h777777, 1'b1);
    chk("mid_count", 32'(count), 32'h0);
    chk("mid_empty", 32'(empty), 32'h1);
    chk("mid_valid", 32'(o_valid), 32'h0);
    chk("mid_udf",   32'(udf), 32'h0);
    chk("mid_ovf",   32'(ovf), 32'h0);
    chk("mid_full",  32'(full), 32'h0);
    chk("mid_af",    32'(almost_full), 32'h0);
    step(1'b0, 1'b0, 24'h0, 1'b0);
    chk("mid_after_count", 32'(count), 32'h0);
    chk("mid_after_valid", 32'(o_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_in_fifo.md
# pixel_in_fifo

Input pixel buffer that sits directly upstream of the detection `model` core. Accepts 3-channel int8 pixels (ch0 in the upper byte) from the frame source, stores them in a synchronous FIFO, and presents them on `o_data`/`o_valid` when the core pulls with `fifo_rd_en`. It generates the `almost_full` back-pressure the source uses to throttle writes, and optionally tags frame boundaries.

## Interface
- `DATA_WIDTH`, 24, pixel width (8 × input channels)
- `DEPTH`, 512, entries; power of two, ≥ 4
- `AF_MARGIN`, 8, `almost_full` asserts when free entries ≤ `AF_MARGIN`
- `FRAME_PIXELS`, 65536, pixels per frame (256×256); used only with the frame-count feature

- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `wr_data`  in  `DATA_WIDTH`  pixel from source, `{ch0,ch1,ch2}`
- `wr_en`  in  1  write strobe
- `full`  out  1  no free entries
- `almost_full`  out  1  free entries ≤ `AF_MARGIN`
- `rd_en`  in  1  pull request; connects to core `fifo_rd_en`
- `o_data`  out  `DATA_WIDTH`  pixel to core `i_data`
- `o_valid`  out  1  `o_data` valid this cycle; connects to core `i_valid`
- `empty`  out  1  no stored entries
- `count`  out  `$clog2(DEPTH+1)`  stored entries
- `ovf`  out  1  sticky: write dropped while full
- `udf`  out  1  sticky: read requested while empty
- `o_last`  out  1  frame-count feature only: marks the last pixel of a frame

## Operation
- Storage: `DEPTH`-entry array; write pointer, read pointer, and occupancy counter. Pointers wrap modulo `DEPTH`.
- Write accepted when `wr_en && (!full || pop)`, where `pop = rd_en && !empty`. A write while full with no pop is dropped and sets `ovf`.
- Pop when `rd_en && !empty`. The entry at the read pointer is registered into `o_data`. `rd_en` while empty sets `udf` and does not pop.
- `count` next = `count + push − pop`. Simultaneous push and pop leave `count` unchanged.
- No fall-through: with `empty`=1, a same-cycle write and read stores the pixel and does not pop it.
- `full` = (`count`==`DEPTH`). `empty` = (`count`==0). `almost_full` = (`DEPTH − count` ≤ `AF_MARGIN`). All three derive from registered `count`.
- `ovf` and `udf` clear only on `rst`.
- Pixel order is preserved exactly. No data transformation.

## Timing
- Read latency is 1: a pop in cycle N gives `o_valid`=1 and the popped `o_data` in cycle N+1. `o_valid`=0 in any cycle following a non-pop.
- `o_data` holds its last value when `o_valid`=0.
- Status flags update the cycle after the push or pop that changes `count`.
- Reset values: `o_data`=0, `o_valid`=0, `full`=0, `almost_full`=0 (given `AF_MARGIN` < `DEPTH`), `empty`=1, `count`=0, `ovf`=0, `udf`=0, `o_last`=0. Pointers are 0.
- `rst` mid-operation discards all contents. Inputs during the `rst` cycle are ignored. Array contents are not cleared.
- Write throughput and read throughput are each 1 per cycle. Sustained simultaneous push/pop keeps `count` constant.

## Configuration
- `PIXEL_FIFO_FRAME_CNT_EN` defined:
  - A popped-pixel counter of width `$clog2(FRAME_PIXELS)` increments on each pop.
  - `o_last`=1, aligned with `o_valid`, for the pop at which the counter equals `FRAME_PIXELS−1`. The counter then wraps to 0.
  - Counter resets to 0 on `rst`.
- Not defined: `o_last` is tied to 0 and no counter exists.

## Test plan
- Reset and drain: after `rst`, write 0x000001..0x000004 in 4 cycles, then `rd_en`=1 for 4 cycles. Required: `o_valid` in cycles 1–4 after the first `rd_en`, `o_data` = 01, 02, 03, 04, and `empty`=1 after the final pop.
- Fill to full (`DEPTH`=512, `AF_MARGIN`=8):
  - `almost_full` rises after the 504th write.
  - `full` rises after the 512th write.
  - A 513th write (0xABCDEF) sets `ovf`=1 and is never read out.
- Simultaneous push/pop at full: with `wr_en`=`rd_en`=1 for 100 cycles, `count` stays at 512, nothing is dropped, `ovf` stays 0, and output order is FIFO.
- Empty edge: with the FIFO empty, `wr_en`=`rd_en`=1 with 0x555555. Required: no `o_valid`, `udf`=1, `count`=1. The next `rd_en` returns 0x555555.
- Reset mid-stream: after 10 writes, assert `rst` for 1 cycle while `wr_en`=1. Required: `count`=0, `empty`=1, `o_valid`=0, flags cleared.
- Frame tag (macro on, `FRAME_PIXELS`=16): stream 40 pixels. Required: `o_last`=1 exactly on pops 16 and 32 and nowhere else.
